// File: rtl/out_sig_pkg.sv
// Shared types, mode constants and the slice-XOR fold used by the output signature collector.
package out_sig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH1,
    ST_FLUSH2,
    ST_EMIT
  } state_e;

  localparam logic MODE_FOLD = 1'b0;
  localparam logic MODE_SIG  = 1'b1;

  // Upper bounds for the generic fold; callers zero-extend into these widths.
  localparam int FOLD_MAX_DIN_W  = 256;
  localparam int FOLD_MAX_DOUT_W = 32;

  // XOR of the din_w/dout_w consecutive dout_w-bit slices of din.
  function automatic logic [FOLD_MAX_DOUT_W-1:0] fold_word(
    input logic [FOLD_MAX_DIN_W-1:0] din,
    input int                        din_w,
    input int                        dout_w
  );
    logic [FOLD_MAX_DIN_W-1:0]  rem;
    logic [FOLD_MAX_DOUT_W-1:0] mask;
    logic [FOLD_MAX_DOUT_W-1:0] res;
    rem  = din;
    res  = '0;
    mask = (FOLD_MAX_DOUT_W'(1) << dout_w) - FOLD_MAX_DOUT_W'(1);
    for (int s = 0; s < FOLD_MAX_DIN_W; s++) begin
      if (s * dout_w < din_w) begin
        res = res ^ (FOLD_MAX_DOUT_W'(rem) & mask);
        rem = rem >> dout_w;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/out_sig_collector_if.sv
// Kernel-side observation signals and pin-level result bus of the output signature collector.
interface out_sig_collector_if #(
  parameter int NUM_CH = 2,
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 4,
  parameter int CNT_W  = 16
);
  logic                     ap_start;
  logic                     ap_done;
  logic                     sig_mode;
  logic [NUM_CH*DIN_W-1:0]  ch_din;
  logic [NUM_CH-1:0]        ch_write;
  logic [DOUT_W-1:0]        data_out;
  logic                     data_valid;
  logic [CNT_W-1:0]         word_cnt;
  logic                     run_done;
  logic                     busy;

  modport master (
    output ap_start, ap_done, sig_mode, ch_din, ch_write,
    input  data_out, data_valid, word_cnt, run_done, busy
  );

  modport slave (
    input  ap_start, ap_done, sig_mode, ch_din, ch_write,
    output data_out, data_valid, word_cnt, run_done, busy
  );
endinterface

// File: rtl/sig_fold_tree.sv
// Per-channel slice fold followed by an XOR across the channels that are writing.
// Latency: combinational.
// Backpressure: none; non-writing channels contribute zero.
module sig_fold_tree
  import out_sig_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 4
) (
  input  logic [NUM_CH*DIN_W-1:0] ch_dat,
  input  logic [NUM_CH-1:0]       ch_vld,
  output logic [DOUT_W-1:0]       fold_dat
);

  logic [FOLD_MAX_DOUT_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_vld[k]) begin
        acc = acc ^ fold_word(FOLD_MAX_DIN_W'(ch_dat[k*DIN_W +: DIN_W]), DIN_W, DOUT_W);
      end
    end
  end

  assign fold_dat = DOUT_W'(acc);

endmodule

// File: rtl/out_sig_collector.sv
// Compresses kernel output write streams onto a narrow result bus as per-word folds or a run signature.
// Latency: write to data_valid 2 cycles (fold mode); ap_done to run_done and signature emit 4 cycles.
// Backpressure: none; writes are always accepted while running and masked otherwise.
module out_sig_collector
  import out_sig_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  out_sig_collector_if.slave bus
);

  state_e              state_q;
  state_e              state_d;
  logic                run_start;
  logic                mode_q;
  logic [NUM_CH-1:0]   acc_wr;
  logic [DOUT_W-1:0]   fold_dat;
  logic                s1_vld;
  logic [DOUT_W-1:0]   s1_dat;
  logic [DOUT_W-1:0]   sig_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                dout_vld_q;
  logic [DOUT_W-1:0]   dout_q;
  logic                run_done_q;

  // The ap_done cycle itself is still RUN, so its coincident write is folded in.
  assign acc_wr = (state_q == ST_RUN) ? bus.ch_write : '0;

  sig_fold_tree #(
    .NUM_CH (NUM_CH),
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W)
  ) u_fold (
    .ch_dat   (bus.ch_din),
    .ch_vld   (acc_wr),
    .fold_dat (fold_dat)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ap_start) begin
          state_d   = ST_RUN;
          run_start = 1'b1;
        end
      end
      ST_RUN:    if (bus.ap_done) state_d = ST_FLUSH1;
      ST_FLUSH1: state_d = ST_FLUSH2;
      ST_FLUSH2: state_d = ST_EMIT;
      ST_EMIT:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= |acc_wr;
      s1_dat <= fold_dat;
    end
  end

  // Run start and a valid stage-1 word never coincide: stage 1 is empty in IDLE.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mode_q <= MODE_FOLD;
      sig_q  <= '0;
      cnt_q  <= '0;
    end else if (run_start) begin
      mode_q <= bus.sig_mode;
      sig_q  <= '0;
      cnt_q  <= '0;
    end else if (s1_vld) begin
      sig_q <= {sig_q[DOUT_W-2:0], sig_q[DOUT_W-1]} ^ s1_dat;
      if (cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
      run_done_q <= 1'b0;
    end else begin
      run_done_q <= (state_q == ST_EMIT);
      if (mode_q == MODE_SIG) begin
        dout_vld_q <= (state_q == ST_EMIT);
        dout_q     <= (state_q == ST_EMIT) ? sig_q : '0;
      end else begin
        dout_vld_q <= s1_vld;
        dout_q     <= s1_vld ? s1_dat : '0;
      end
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = dout_vld_q;
  assign bus.word_cnt   = cnt_q;
  assign bus.run_done   = run_done_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: doc/out_sig_collector.md
Name: out_sig_collector

Overview:
- Output-observation stage placed after an HLS kernel in the board-level test harness.
- Compresses one or more kernel output FIFO-write streams into a narrow pin-level result bus.
- Supersedes the fixed 32→4-bit single-stream XOR fold with:
  - parametrised channel count and input/output widths;
  - a run-time selectable signature (MISR-style) mode;
  - a run controller tied to ap_start/ap_done, a word counter and a run-done pulse.

Parameters:
- NUM_CH, 2: number of kernel output streams observed.
- DIN_W, 32: width of each stream's data word. Must be a multiple of DOUT_W.
- DOUT_W, 4: width of data_out and of the signature register. Must be ≥ 2.
- CNT_W, 16: width of the saturating accepted-word counter.

Ports:
- ap_clk  in  1  single clock.
- ap_rst_n  in  1  asynchronous, active-low reset.
- ap_start  in  1  kernel start level, as driven to the kernel.
- ap_done  in  1  kernel done pulse.
- sig_mode  in  1  0 = per-word fold, 1 = run signature. Sampled on run start.
- ch_din  in  NUM_CH*DIN_W  concatenated stream data. Channel k occupies bits [k*DIN_W +: DIN_W].
- ch_write  in  NUM_CH  per-channel write strobe.
- data_out  out  DOUT_W  folded word or final signature.
- data_valid  out  1  data_out qualifier.
- word_cnt  out  CNT_W  number of accepted cycles in the current/last run.
- run_done  out  1  one-cycle pulse at end of run.
- busy  out  1  high while state ≠ IDLE.

Behaviour:
- Reset (async, ap_rst_n low): all outputs 0; state IDLE; signature and counter cleared; pipeline valid bits cleared. Reset mid-run aborts the run with no emit and no run_done.
- Fold:
  - Each channel's word is XOR of its DIN_W/DOUT_W slices of DOUT_W bits.
  - The combined fold is XOR of folded values over channels whose ch_write is high.
  - Channels with write low contribute 0.
- Accept window:
  - Writes are accepted in state RUN, including the cycle ap_done is high.
  - Writes in IDLE, FLUSH or EMIT are masked and neither folded nor counted.
- Pipeline:
  - Stage 1 registers fold_s1 and valid_s1 (valid_s1 = OR of accepted writes).
  - Stage 2 registers the outputs / updates the signature.
- word_cnt increments by 1 per cycle with valid_s1 high, regardless of how many channels wrote; it saturates at all-ones.
- Mode 0:
  - data_valid = valid_s1 delayed one register; data_out = fold_s1 when valid, else 0.
  - Write at cycle t gives data_valid at t+2.
  - Nothing is emitted at end of run except run_done.
- Mode 1:
  - data_valid and data_out stay 0 during RUN.
  - On valid_s1: sig ← rotl(sig,1) ^ fold_s1.
  - At EMIT: data_valid = 1 and data_out = sig for exactly one cycle.
- FSM:
  - IDLE → RUN on ap_start high. Clear sig and word_cnt; latch sig_mode.
  - RUN → FLUSH1 on ap_done.
  - FLUSH1 → FLUSH2 → EMIT, unconditional.
  - EMIT → IDLE.
- End-of-run timing: ap_done high at cycle t gives run_done (and the mode-1 emit) high at t+4. A write in cycle t is included in the signature and the count.
- ap_start while not IDLE is ignored.
- ap_start still high on return to IDLE starts a new run immediately, so ap_start must be a level that the harness drops.
- ap_done in IDLE or FLUSH is ignored.
- word_cnt holds its value in IDLE until the next run start.

Decomposition:
- Shared package out_sig_pkg holds:
  - the state enum (IDLE, RUN, FLUSH1, FLUSH2, EMIT);
  - the MODE_FOLD/MODE_SIG constants;
  - a fold function (DIN_W → DOUT_W XOR-reduce).
- One sub-module, sig_fold_tree: combinational per-channel fold plus cross-channel XOR, parametrised by NUM_CH, DIN_W, DOUT_W.
- The top holds the FSM, the pipeline, the signature and the counter.

Test Plan:
- Mode 0, NUM_CH=1, ch_din=0x12345678 written at t → data_valid high at t+2, data_out=0x8; word_cnt=1.
- Mode 0, both channels write at once, ch0=0x12345678, ch1=0x0000000F → single data_out=0x7; word_cnt increments by 1.
- Mode 1, words 0x00000001 then 0x00000003, then ap_done at t → data_valid and run_done high only at t+4, data_out=0x1, word_cnt=2. Also hold a third write coincident with ap_done and check it is included.
- CNT_W=2, 5 accepted writes → word_cnt=3 (saturated). Writes issued in FLUSH1 → not counted and no data_valid.
- ap_rst_n low in FLUSH2 of a mode-1 run → outputs immediately 0, no run_done afterwards. A fresh ap_start then yields a clean run with sig starting from 0.
- ap_start pulsed during RUN and ap_done pulsed in IDLE → no state change, no outputs.
